// File: rtl/qpm_pkg.sv
// rtl/qpm_pkg.sv - shared types and defaults for the query-patch SRAM sequencer
package qpm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    READ   = 2'd3
  } qpm_state_e;

  localparam int QPM_DATA_WIDTH = 11;
  localparam int QPM_PATCH_SIZE = 5;
  localparam int QPM_PW         = QPM_DATA_WIDTH * QPM_PATCH_SIZE;
  localparam int QPM_ADDR_WIDTH = 9;
  localparam int QPM_DEPTH      = 512;
  localparam int QPM_RD_LATENCY = 2;
  localparam int QPM_FIFO_DEPTH = 4;

endpackage

// File: rtl/qpm_skid_fifo.sv
// rtl/qpm_skid_fifo.sv - small output skid FIFO with occupancy count and sync clear
module qpm_skid_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/query_patch_mem_ctrl.sv
// rtl/query_patch_mem_ctrl.sv - LOAD/READ sequencer for the query-patch SRAM wrapper
module query_patch_mem_ctrl
  import qpm_pkg::*;
#(
  parameter int DATA_WIDTH = QPM_DATA_WIDTH,
  parameter int PATCH_SIZE = QPM_PATCH_SIZE,
  parameter int ADDR_WIDTH = QPM_ADDR_WIDTH,
  parameter int DEPTH      = QPM_DEPTH,
  parameter int RD_LATENCY = QPM_RD_LATENCY,
  parameter int FIFO_DEPTH = QPM_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  input  logic [ADDR_WIDTH:0]              load_count,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] in_patch,
  output logic                             load_done,
  input  logic                             rd_start,
  input  logic [ADDR_WIDTH-1:0]            rd_base,
  input  logic [ADDR_WIDTH:0]              rd_len,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] out_patch,
  output logic                             out_last,
  output logic                             rd_done,
  output logic                             cmd_err,
  output logic                             busy,
  output logic                             mem_csb0,
  output logic                             mem_web0,
  output logic [ADDR_WIDTH-1:0]            mem_addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] mem_wpatch0,
  output logic                             mem_csb1,
  output logic [ADDR_WIDTH-1:0]            mem_addr1,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] mem_rpatch1
);

  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  qpm_state_e state, state_nxt;

  logic [LW-1:0]         load_count_q;
  logic [LW-1:0]         wr_cnt;
  logic [LW-1:0]         rd_len_q;
  logic [LW-1:0]         issued_cnt;
  logic [LW-1:0]         popped_cnt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [RD_LATENCY-1:0] rd_vld_sr;
  logic                  load_done_q, rd_done_q, cmd_err_q;

  logic          load_cmd_ok, rd_cmd_ok, cmd_bad;
  logic          wr_fire, wr_last, issue, pop, rd_last_pop;
  logic [CW-1:0] fifo_count, inflight;
  logic [CW:0]   occupancy;
  logic          fifo_empty, fifo_full;
  logic [PW-1:0] fifo_data;

  assign load_cmd_ok = load_start && (state == IDLE || state == LOADED) &&
                       (load_count != '0) && (load_count <= DEPTH_L);
  // load_start wins a same-cycle collision, so the rd_start is reported as ignored
  assign rd_cmd_ok   = rd_start && !load_start && (state == LOADED);
  assign cmd_bad     = (load_start && !load_cmd_ok) || (rd_start && !rd_cmd_ok);

  assign wr_last     = wr_fire && ((wr_cnt + LW'(1)) == load_count_q);
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_last    = out_valid && ((popped_cnt + LW'(1)) == rd_len_q);
  assign rd_last_pop = pop && out_last;
  assign out_patch   = out_valid ? fifo_data : '0;
  assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};

  assign load_done = load_done_q;
  assign rd_done   = rd_done_q;
  assign cmd_err   = cmd_err_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(rd_vld_sr[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_cmd_ok) state_nxt = LOAD;
      LOAD:    if (wr_last) state_nxt = LOADED;
      LOADED: begin
        if (load_cmd_ok)                        state_nxt = LOAD;
        else if (rd_cmd_ok && rd_len != '0)     state_nxt = READ;
      end
      READ:    if (rd_last_pop) state_nxt = LOADED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b0;
    wr_fire     = 1'b0;
    issue       = 1'b0;
    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = '0;
    mem_wpatch0 = '0;
    mem_csb1    = 1'b1;
    mem_addr1   = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        wr_fire  = in_valid;
        if (in_valid) begin
          mem_csb0    = 1'b0;
          mem_web0    = 1'b0;
          mem_addr0   = wr_cnt[ADDR_WIDTH-1:0];
          mem_wpatch0 = in_patch;
        end
      end
      READ: begin
        busy = 1'b1;
        // reserve a FIFO slot for every read still travelling through the macro
        issue = (issued_cnt < rd_len_q) && (occupancy < (CW+1)'(FIFO_DEPTH));
        if (issue) begin
          mem_csb1  = 1'b0;
          mem_addr1 = rd_ptr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_count_q <= '0;
      wr_cnt       <= '0;
      rd_len_q     <= '0;
      issued_cnt   <= '0;
      popped_cnt   <= '0;
      rd_ptr       <= '0;
      rd_vld_sr    <= '0;
      load_done_q  <= 1'b0;
      rd_done_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      load_done_q <= wr_last;
      rd_done_q   <= rd_last_pop || (rd_cmd_ok && rd_len == '0);
      cmd_err_q   <= cmd_bad;
      // clearing the valid pipe on reset is what squashes reads still in the macro
      rd_vld_sr   <= (rd_vld_sr << 1) | RD_LATENCY'(issue);

      if (load_cmd_ok) begin
        load_count_q <= load_count;
        wr_cnt       <= '0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + LW'(1);
      end

      if (rd_cmd_ok) begin
        rd_len_q   <= rd_len;
        rd_ptr     <= rd_base;
        issued_cnt <= '0;
        popped_cnt <= '0;
      end else begin
        if (issue) begin
          rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
          issued_cnt <= issued_cnt + LW'(1);
        end
        if (pop) popped_cnt <= popped_cnt + LW'(1);
      end
    end
  end

  qpm_skid_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_skid_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (rd_cmd_ok),
    .push      (rd_vld_sr[RD_LATENCY-1]),
    .push_data (mem_rpatch1),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_query_patch_mem_ctrl.sv
// tb/tb_query_patch_mem_ctrl.sv - randomized self-checking bench for query_patch_mem_ctrl
module tb_query_patch_mem_ctrl;

  localparam int PW = 55;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_count;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_patch;
  logic          load_done;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_patch;
  logic          out_last;
  logic          rd_done;
  logic          cmd_err;
  logic          busy;
  logic          mem_csb0, mem_web0, mem_csb1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [PW-1:0] mem_wpatch0, mem_rpatch1;

  query_patch_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_count(load_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .load_done(load_done),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch), .out_last(out_last),
    .rd_done(rd_done), .cmd_err(cmd_err), .busy(busy),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0), .mem_wpatch0(mem_wpatch0),
    .mem_csb1(mem_csb1), .mem_addr1(mem_addr1), .mem_rpatch1(mem_rpatch1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM wrapper: macro read register plus wrapper register, junk when port 1 idle
  logic [PW-1:0] sram [DEPTH];
  logic [PW-1:0] p1, p2;
  always @(posedge clk) begin
    if (!mem_csb0 && !mem_web0) sram[mem_addr0] <= mem_wpatch0;
    if (!mem_csb1) p1 <= sram[mem_addr1];
    else           p1 <= PW'({$urandom(), $urandom()});
    p2 <= p1;
  end
  assign mem_rpatch1 = p2;

  logic [AW-1:0] wr_addr_q[$];
  logic [PW-1:0] wr_data_q[$];
  logic [AW-1:0] iss_q[$];
  logic [PW-1:0] out_q[$];
  logic          last_q[$];
  int            ocyc_q[$];
  int load_done_cnt = 0, load_done_cyc = 0;
  int rd_done_cnt = 0, rd_done_cyc = 0;
  int cmd_err_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_csb0 && !mem_web0) begin
        wr_addr_q.push_back(mem_addr0);
        wr_data_q.push_back(mem_wpatch0);
      end
      if (!mem_csb1) iss_q.push_back(mem_addr1);
      if (out_valid && out_ready) begin
        out_q.push_back(out_patch);
        last_q.push_back(out_last);
        ocyc_q.push_back(cyc);
      end
      if (load_done) begin load_done_cnt++; load_done_cyc = cyc; end
      if (rd_done)   begin rd_done_cnt++;   rd_done_cyc   = cyc; end
      if (cmd_err)   cmd_err_cnt++;
    end
  end

  // reference contents: what the bench handed over, indexed by patch number
  logic [PW-1:0] shadow [DEPTH];
  int checks = 0, errors = 0;
  int c0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_patch();
    return PW'({$urandom(), $urandom()});
  endfunction

  task automatic feed(input int n, input int pct);
    int k = 0;
    int t = 0;
    while (k < n && t < 5000) begin
      in_valid = ($urandom_range(99) < pct);
      in_patch = rand_patch();
      @(negedge clk);
      if (in_valid && in_ready) begin
        shadow[k] = in_patch;
        k++;
      end
      step();
      t++;
    end
    in_valid = 1'b0;
    check("feed_accepted", k, n);
  endtask

  task automatic do_load(input int n, input int pct, input int w0, input int d0);
    int t = 0;
    feed(n, pct);
    while (load_done_cnt == d0 && t < 50) begin step(); t++; end
    check("load_done_pulses", load_done_cnt - d0, 1);
    check("load_writes", wr_addr_q.size() - w0, n);
    for (int i = 0; i < n && w0 + i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr_q[w0+i], i);
      check($sformatf("wr_data[%0d]", i), wr_data_q[w0+i], shadow[i]);
    end
  endtask

  task automatic do_read(input int base, input int len, input int pct, input int bound);
    int o0 = out_q.size();
    int i0 = iss_q.size();
    int r0 = rd_done_cnt;
    int t = 0;
    rd_base   = AW'(base);
    rd_len    = (AW+1)'(len);
    rd_start  = 1'b1;
    out_ready = ($urandom_range(99) < pct);
    c0 = cyc;
    step();
    rd_start = 1'b0;
    while (rd_done_cnt == r0 && t < bound) begin
      out_ready = ($urandom_range(99) < pct);
      step();
      t++;
    end
    out_ready = 1'b0;
    check("rd_done_pulses", rd_done_cnt - r0, 1);
    check("rd_out_count", out_q.size() - o0, len);
    check("rd_issue_count", iss_q.size() - i0, len);
    for (int i = 0; i < len && o0 + i < out_q.size(); i++) begin
      check($sformatf("rd_data[%0d]", i), out_q[o0+i], shadow[(base + i) % DEPTH]);
      check($sformatf("rd_last[%0d]", i), last_q[o0+i], (i == len - 1));
    end
    for (int i = 0; i < len && i0 + i < iss_q.size(); i++)
      check($sformatf("rd_addr1[%0d]", i), iss_q[i0+i], (base + i) % DEPTH);
  endtask

  initial begin
    int o0, vcount;
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int o0, vcount;
    rst = 1'b1; load_start = 1'b0; load_count = '0; in_valid = 1'b0; in_patch = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {load_done, rd_done, cmd_err}, 0);
    check("rst_csb_web", {mem_csb0, mem_web0, mem_csb1}, 3'b111);
    check("rst_addrs", {mem_addr0, mem_addr1}, 0);
    step();
    rst = 1'b0;
    step();

    // load 8 back-to-back: load_done 9 cycles after load_start
    load_count = 10'd8; load_start = 1'b1; c0 = cyc;
    step();
    load_start = 1'b0;
    do_load(8, 100, 0, 0);
    check("load8_done_latency", load_done_cyc - c0, 9);

    do_read(4, 4, 100, 50);
    if (ocyc_q.size() >= 4)
      check("rd4_back_to_back", ocyc_q[ocyc_q.size()-1] - ocyc_q[ocyc_q.size()-4], 3);

    // load_count == 0 in LOADED is ignored
    load_count = '0; load_start = 1'b1;
    step();
    load_start = 1'b0;
    @(negedge clk);
    check("cmd_err_count0", cmd_err, 1);
    check("count0_busy", busy, 0);
    step();

    // load_start + rd_start together: load wins, rd_start flagged
    o0 = wr_addr_q.size();
    vcount = load_done_cnt;
    load_count = 10'd512; load_start = 1'b1; rd_start = 1'b1; rd_base = '0; rd_len = 10'd4;
    step();
    load_start = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    check("cmd_err_collide", cmd_err, 1);
    check("collide_in_load", in_ready, 1);
    step();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    check("cmd_err_rd_in_load", cmd_err, 1);
    check("rd_in_load_busy", busy, 1);
    step();
    do_load(512, 70, o0, vcount);

    do_read(510, 4, 100, 50);
    do_read(int'($urandom_range(511)), 64, 30, 2000);
    do_read(int'($urandom_range(511)), 37, 80, 2000);

    do_read(7, 0, 100, 20);
    check("len0_done_latency", rd_done_cyc - c0, 1);
    @(negedge clk);
    check("len0_busy", busy, 0);
    step();

    // oversize load_count is ignored
    load_count = 10'd513; load_start = 1'b1;
    step();
    load_start = 1'b0;
    @(negedge clk);
    check("cmd_err_count513", cmd_err, 1);
    check("count513_busy", busy, 0);
    step();
    check("cmd_err_total", cmd_err_cnt, 4);

    // reset with two reads still inside the macro
    rd_base = 9'd100; rd_len = 10'd16; rd_start = 1'b1; out_ready = 1'b0;
    step();
    rd_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_csb1", mem_csb1, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("rst_mid_stale_outputs", vcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
